// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle multiply/divide unit with architectural HI/LO registers
module muldiv_hilo_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_signed;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_op_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_last;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Decode, operand magnitudes, product and one restoring-division step
    always_comb begin
        w_is_mul    = (op == 3'd1) || (op == 3'd2);
        w_is_div    = (op == 3'd3) || (op == 3'd4);
        w_op_signed = (op == 3'd1) || (op == 3'd3);
        w_a_mag     = (w_op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
        w_b_mag     = (w_op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
        w_last      = ((r_state == S_MUL) && (r_cnt == MUL_LAST)) ||
                      ((r_state == S_DIV) && (r_cnt == DIV_LAST));
        // Sign-extended 2W-bit operands make one unsigned multiplier serve both flavours
        w_ext_a     = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
        w_ext_b     = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
        w_prod      = w_ext_a * w_ext_b;
        w_shift     = {r_rem, r_quo[WIDTH-1]};
        w_diff      = w_shift - {1'b0, r_divisor};
        w_ge        = (w_shift >= {1'b0, r_divisor});
        w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_next  = {r_quo[WIDTH-2:0], w_ge};
        w_q_fix     = r_neg_q ? -w_quo_next : w_quo_next;
        w_r_fix     = r_neg_r ? -w_rem_next : w_rem_next;
    end

    // Handshake outputs; accept-cycle stall is combinational so the pipeline holds the op
    always_comb begin
        stall = reset && !flush &&
                ((r_state == S_MUL) || (r_state == S_DIV) ||
                 ((r_state == S_IDLE) && valid && (w_is_mul || w_is_div)));
        done  = reset && !flush && (r_state == S_DONE);
    end

    // Control FSM, operand capture, iterative datapath and HI/LO update
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        if (w_is_mul || w_is_div) begin
                            r_state   <= w_is_mul ? S_MUL : S_DIV;
                            r_cnt     <= '0;
                            r_signed  <= w_op_signed;
                            r_a       <= src_a;
                            r_b       <= src_b;
                            r_divisor <= w_b_mag;
                            r_rem     <= '0;
                            r_quo     <= w_a_mag;
                            r_neg_q   <= w_op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            r_neg_r   <= w_op_signed && src_a[WIDTH-1];
                        end else if (op == 3'd5) begin
                            hi <= src_a;
                        end else if (op == 3'd6) begin
                            lo <= src_a;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        hi      <= w_prod[2*WIDTH-1:WIDTH];
                        lo      <= w_prod[WIDTH-1:0];
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    if (w_last) begin
                        // Zero divisor returns all-ones quotient and the raw dividend
                        if (r_b == '0) begin
                            hi <= r_a;
                            lo <= '1;
                        end else begin
                            hi <= w_r_fix;
                            lo <= w_q_fix;
                        end
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - scoreboard testbench for muldiv_hilo_unit
module tb_muldiv_hilo_unit;

    logic        clock;
    logic        reset;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [63:0] sb_q[$];
    logic [63:0] m_hilo = 64'd0;

    muldiv_hilo_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .valid (valid),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference {hi,lo} computed with wide integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = 64'd0;
        case (o)
            3'd1: res = 64'(sa * sb);
            3'd2: res = {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Scoreboard consumer: every done pulse retires the oldest expected result
    always @(negedge clock) begin
        #2;
        if (done) begin
            if (sb_q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
            else chk("hilo", {hi, lo}, sb_q.pop_front());
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int lat);
        int n;
        m_hilo = model(o, a, b);
        sb_q.push_back(m_hilo);
        @(negedge clock);
        valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        chk("accept_stall", {63'd0, stall}, 64'd1);
        n = 0;
        do begin
            @(negedge clock);
            #1;
            n++;
            if (!done) chk("busy_stall", {63'd0, stall}, 64'd1);
        end while (!done && n < 100);
        chk("latency", 64'(n), 64'(lat + 1));
        chk("done_stall", {63'd0, stall}, 64'd0);
        @(negedge clock);
        valid = 1'b0; op = 3'd0;
        #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; op = 3'd0; src_a = '0; src_b = '0; flush = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFD, 32'd5, 2);
        do_op(3'd2, 32'hFFFF_FFFD, 32'd5, 2);
        do_op(3'd4, 32'd100, 32'd7, 32);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 32);
        do_op(3'd3, 32'd5, 32'd0, 32);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32);
        do_op(3'd4, 32'hDEAD_BEEF, 32'd0, 32);
        do_op(3'd3, 32'd17, 32'hFFFF_FFFB, 32);

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(1, 4));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            do_op(ro, ra, rb, (ro <= 3'd2) ? 2 : 32);
        end

        // MTHI then MTLO back-to-back, never stalling
        @(negedge clock);
        valid = 1'b1; op = 3'd5; src_a = 32'h1234_5678;
        #1;
        chk("mthi_stall", {63'd0, stall}, 64'd0);
        @(negedge clock);
        op = 3'd6; src_a = 32'h9ABC_DEF0;
        #1;
        chk("mtlo_stall", {63'd0, stall}, 64'd0);
        @(negedge clock);
        valid = 1'b0; op = 3'd0;
        #1;
        m_hilo = 64'h1234_5678_9ABC_DEF0;
        chk("mthi_mtlo", {hi, lo}, m_hilo);

        do_op(3'd4, 32'd1000, 32'd9, 32);

        // Flush ten cycles after accepting a divide
        @(negedge clock);
        valid = 1'b1; op = 3'd4; src_a = 32'd12345; src_b = 32'd11;
        #1;
        chk("fl_accept_stall", {63'd0, stall}, 64'd1);
        repeat (9) @(negedge clock);
        @(negedge clock);
        flush = 1'b1;
        #1;
        chk("fl_stall", {63'd0, stall}, 64'd0);
        chk("fl_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        flush = 1'b0; valid = 1'b0; op = 3'd0;
        #1;
        chk("fl_idle_stall", {63'd0, stall}, 64'd0);
        repeat (40) @(negedge clock);
        #1;
        chk("fl_hilo", {hi, lo}, m_hilo);

        // Reset ten cycles after accepting a divide
        @(negedge clock);
        valid = 1'b1; op = 3'd4; src_a = 32'd5555; src_b = 32'd3;
        #1;
        chk("rs_accept_stall", {63'd0, stall}, 64'd1);
        repeat (9) @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rs_stall", {63'd0, stall}, 64'd0);
        @(negedge clock);
        reset = 1'b1; valid = 1'b0; op = 3'd0;
        #1;
        m_hilo = 64'd0;
        chk("rs_hilo", {hi, lo}, m_hilo);
        chk("rs_idle_stall", {63'd0, stall}, 64'd0);
        repeat (40) @(negedge clock);
        #1;
        chk("rs_hilo_hold", {hi, lo}, m_hilo);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width (even, >=8).
REQ-002 The block SHALL have parameter MUL_LAT, default 2, meaning multiply latency in cycles (>=1).
REQ-003 clock  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on rising edge of clock.
REQ-005 valid  input  1  op/src_a/src_b present this cycle.
REQ-006 op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-008 src_b  input  WIDTH  multiplier / divisor.
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 stall  output  1  pipeline must hold op/src inputs stable.
REQ-011 done  output  1  one-cycle pulse: HI/LO updated by the retiring mul/div.
REQ-012 hi, lo  output  WIDTH each  architectural HI/LO registers.

Function
REQ-013 States SHALL be IDLE, MUL, DIV, DONE.
REQ-014 In IDLE, valid with op MULT/MULTU/DIV/DIVU SHALL accept the op: operands latched, stall=1 combinationally that cycle, next state MUL or DIV.
REQ-015 MUL SHALL last exactly MUL_LAT cycles; DIV SHALL last exactly WIDTH cycles (radix-2, one quotient bit per cycle); stall=1 throughout.
REQ-016 HI/LO SHALL be written at the edge ending the last MUL/DIV cycle; next state DONE.
REQ-017 DONE SHALL last one cycle with done=1, stall=0, inputs ignored (retiring instruction still presented); next state IDLE.
REQ-018 Latency from accept cycle t: done=1 in cycle t+MUL_LAT+1 (multiply) or t+WIDTH+1 (divide).
REQ-019 MTHI in IDLE with valid SHALL write hi<=src_a at the edge, lo unchanged, no stall; MTLO symmetric for lo.
REQ-020 MULT/MULTU SHALL produce the 2*WIDTH signed/unsigned product, {hi,lo} = product.
REQ-021 DIV/DIVU SHALL give lo=quotient, hi=remainder; signed: quotient truncated toward zero, remainder takes dividend sign.
REQ-022 Divisor zero SHALL give lo=all-ones, hi=src_a, same latency.
REQ-023 Signed DIV of most-negative value by -1 SHALL give lo=most-negative value, hi=0.
REQ-024 flush=1 SHALL force IDLE at the next edge from any state, suppress the pending HI/LO write and done; stall=0 in the flush cycle; flush in IDLE with valid SHALL suppress accept and MTHI/MTLO writes.
REQ-025 HI/LO SHALL change only per REQ-016/019/026.

Reset
REQ-026 reset=0 at an edge SHALL set state=IDLE, hi=0, lo=0, done=0, discard any in-flight op; stall SHALL be 0 while reset=0; reset has priority over flush and valid.

Verification
REQ-027 WIDTH=32, MUL_LAT=2: MULT src_a=0xFFFFFFFD, src_b=5 accepted cycle t -> done at t+3, hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU same operands -> hi=0x00000004, lo=0xFFFFFFF1.
REQ-028 DIVU 100/7 accepted cycle t -> stall=1 cycles t..t+32, done=1 and stall=0 at t+33, lo=14, hi=2; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-029 DIV 5/0 -> lo=0xFFFFFFFF, hi=5 at t+33; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi=0x12345678, lo=0x9ABCDEF0, stall never asserted; then DIVU held over DONE cycle -> exactly one done pulse, no re-accept.
REQ-031 DIVU accepted, flush at t+10 -> IDLE at t+11, no done, hi/lo unchanged; separately reset=0 at t+10 -> hi=lo=0, stall=0, done never pulses.
